// File: rtl/sync_strobe_tracker.sv
// sync_strobe_tracker: receive-side tracker for a one-cycle sync strobe.
// Measures the strobe period, locks after LOCK_CNT correct intervals,
// regenerates phase and a validated strobe, and counts early/missing strobes.
// Optional macro SYNC_FLYWHEEL_EN: while locked, a missing strobe is replaced
// by a synthetic one until MISS_MAX consecutive misses have been seen.
module sync_strobe_tracker #(
  parameter int DIV      = 50,
  parameter int CW       = 7,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sync,
  input  logic          i_clear,
  output logic          o_locked,
  output logic          o_strobe,
  output logic [CW-1:0] o_phase,
  output logic [CW-1:0] o_period,
  output logic          o_err_early,
  output logic          o_err_miss,
  output logic [7:0]    o_err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [3:0]    LOCK_LAST = 4'(LOCK_CNT - 1);

  state_t        state_reg;
  logic [CW-1:0] icnt_reg;
  logic [3:0]    good_cnt_reg;

  logic at_last;
  logic tracking;
  logic early_hit;
  logic miss_hit;
  logic fly_slip;

  // The interval counter sits at DIV-1 on the cycle a correct strobe is due.
  assign at_last   = (icnt_reg == LAST);
  assign tracking  = (state_reg == VERIFY) || (state_reg == LOCKED);
  assign early_hit = tracking && i_sync && !at_last;
  assign miss_hit  = tracking && !i_sync && at_last;
  assign o_phase   = icnt_reg;

`ifdef SYNC_FLYWHEEL_EN
  localparam logic [3:0] MISS_LAST = 4'(MISS_MAX - 1);
  logic [3:0] miss_cnt_reg;
  // A tolerated miss while locked restarts the interval as if a strobe came.
  assign fly_slip = (state_reg == LOCKED) && miss_hit && (miss_cnt_reg != MISS_LAST);
`else
  assign fly_slip = 1'b0;
`endif

  // Interval counter and period measurement, both saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      icnt_reg <= '0;
      o_period <= '0;
    end else if (i_sync) begin
      icnt_reg <= '0;
      o_period <= (icnt_reg == CNT_MAX) ? CNT_MAX : icnt_reg + 1'b1;
    end else if (fly_slip) begin
      icnt_reg <= '0;
    end else if (icnt_reg != CNT_MAX) begin
      icnt_reg <= icnt_reg + 1'b1;
    end
  end

  // Lock FSM with registered lock/strobe/error outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= HUNT;
      good_cnt_reg <= '0;
`ifdef SYNC_FLYWHEEL_EN
      miss_cnt_reg <= '0;
`endif
      o_locked     <= 1'b0;
      o_strobe     <= 1'b0;
      o_err_early  <= 1'b0;
      o_err_miss   <= 1'b0;
    end else begin
      o_strobe    <= 1'b0;
      o_err_early <= early_hit;
      o_err_miss  <= miss_hit;
      case (state_reg)
        HUNT: begin
          if (i_sync) begin
            state_reg    <= VERIFY;
            good_cnt_reg <= '0;
          end
        end
        VERIFY: begin
          if (i_sync) begin
            if (!at_last) begin
              good_cnt_reg <= '0;
            end else if (good_cnt_reg == LOCK_LAST) begin
              state_reg    <= LOCKED;
              good_cnt_reg <= '0;
`ifdef SYNC_FLYWHEEL_EN
              miss_cnt_reg <= '0;
`endif
              o_locked     <= 1'b1;
              o_strobe     <= 1'b1;
            end else begin
              good_cnt_reg <= good_cnt_reg + 4'd1;
            end
          end else if (at_last) begin
            state_reg <= HUNT;
          end
        end
        LOCKED: begin
          if (i_sync) begin
            if (at_last) begin
              o_strobe <= 1'b1;
`ifdef SYNC_FLYWHEEL_EN
              miss_cnt_reg <= '0;
`endif
            end else begin
              state_reg    <= VERIFY;
              good_cnt_reg <= '0;
              o_locked     <= 1'b0;
            end
          end else if (at_last) begin
`ifdef SYNC_FLYWHEEL_EN
            if (miss_cnt_reg == MISS_LAST) begin
              state_reg    <= HUNT;
              miss_cnt_reg <= '0;
              o_locked     <= 1'b0;
            end else begin
              miss_cnt_reg <= miss_cnt_reg + 4'd1;
              o_strobe     <= 1'b1;
            end
`else
            state_reg <= HUNT;
            o_locked  <= 1'b0;
`endif
          end
        end
        default: begin
          state_reg <= HUNT;
          o_locked  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; a clear overrides a coincident error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= 8'd0;
    end else if (i_clear) begin
      o_err_cnt <= 8'd0;
    end else if ((early_hit || miss_hit) && (o_err_cnt != 8'hFF)) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sync_strobe_tracker.sv
// tb_sync_strobe_tracker: directed scenarios plus random strobe traffic,
// compared every cycle against an interval-level behavioural model.
module tb_sync_strobe_tracker;

  localparam int DIV      = 50;
  localparam int CW       = 7;
  localparam int LOCK_CNT = 4;
  localparam int MISS_MAX = 2;
  localparam int SAT      = (1 << CW) - 1;
`ifdef SYNC_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_sync = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_locked;
  logic          o_strobe;
  logic [CW-1:0] o_phase;
  logic [CW-1:0] o_period;
  logic          o_err_early;
  logic          o_err_miss;
  logic [7:0]    o_err_cnt;

  int errors = 0;
  int checks = 0;

  sync_strobe_tracker #(.DIV(DIV), .CW(CW), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_sync), .i_clear(i_clear),
    .o_locked(o_locked), .o_strobe(o_strobe), .o_phase(o_phase), .o_period(o_period),
    .o_err_early(o_err_early), .o_err_miss(o_err_miss), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (interval lengths, mode, tallies) -----
  int m_since   = 0;   // cycles elapsed in the current interval
  int m_mode    = 0;   // 0 searching, 1 confirming, 2 locked
  int m_goods   = 0;
  int m_misses  = 0;
  int m_period  = 0;
  int m_errs    = 0;
  bit m_strobe  = 0;
  bit m_early   = 0;
  bit m_miss    = 0;
  bit m_locked  = 0;

  always @(posedge i_clk or negedge i_rst_n) begin : model
    bit full;
    bit synth;
    if (!i_rst_n) begin
      m_since = 0; m_mode = 0; m_goods = 0; m_misses = 0; m_period = 0;
      m_errs = 0; m_strobe = 0; m_early = 0; m_miss = 0; m_locked = 0;
    end else begin
      full     = (m_since + 1 == DIV);   // a DIV-long interval ends this cycle
      synth    = 1'b0;
      m_strobe = 1'b0;
      m_early  = (m_mode != 0) && i_sync && !full;
      m_miss   = (m_mode != 0) && !i_sync && full;
      if ((m_early || m_miss) && m_errs < 255) m_errs++;
      if (i_clear) m_errs = 0;
      if (i_sync) begin
        m_period = (m_since + 1 > SAT) ? SAT : m_since + 1;
        if (m_mode == 0 || !full) begin
          m_mode = 1; m_goods = 0;
        end else if (m_mode == 1) begin
          m_goods++;
          if (m_goods == LOCK_CNT) begin m_mode = 2; m_misses = 0; m_strobe = 1; end
        end else begin
          m_strobe = 1; m_misses = 0;
        end
      end else if (full && m_mode != 0) begin
        if (m_mode == 2 && FLY && m_misses + 1 < MISS_MAX) begin
          m_misses++; m_strobe = 1; synth = 1;
        end else begin
          m_mode = 0;
        end
      end
      m_since  = (i_sync || synth) ? 0 : ((m_since > 1000) ? m_since : m_since + 1);
      m_locked = (m_mode == 2);
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge i_clk) begin
    check("locked",   int'(o_locked),    int'(m_locked));
    check("strobe",   int'(o_strobe),    int'(m_strobe));
    check("phase",    int'(o_phase),     (m_since > SAT) ? SAT : m_since);
    check("period",   int'(o_period),    m_period);
    check("early",    int'(o_err_early), int'(m_early));
    check("miss",     int'(o_err_miss),  int'(m_miss));
    check("err_cnt",  int'(o_err_cnt),   m_errs);
  end

  // ---------------- stimulus helpers -----------------------------------------
  bit rnd_clear = 1'b0;

  task automatic step(input bit s, input bit clr);
    i_sync  = s;
    i_clear = clr;
    @(negedge i_clk);
    i_sync  = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic pulse();
    step(1'b1, rnd_clear && ($urandom_range(0, 29) == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rnd_clear && ($urandom_range(0, 29) == 0));
  endtask

  task automatic verify4(input string tag);
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      idle(DIV - 1); pulse();
      check({tag, "_prelock"}, int'(o_locked), 0);
    end
    idle(DIV - 1); pulse();
    check({tag, "_lock"},        int'(o_locked), 1);
    check({tag, "_lock_strobe"}, int'(o_strobe), 1);
    check({tag, "_model_lock"},  int'(m_locked), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    int gap;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    check("reset_locked",  int'(o_locked),  0);
    check("reset_phase",   int'(o_phase),   0);
    check("reset_err_cnt", int'(o_err_cnt), 0);

    // clean lock: fifth strobe (t0+200) gives lock and strobe one cycle later
    pulse();
    verify4("clean");
    check("clean_phase",  int'(o_phase),   0);
    check("clean_period", int'(o_period),  DIV);
    check("clean_errs",   int'(o_err_cnt), 0);
    idle(DIV - 1); pulse();
    check("steady_strobe", int'(o_strobe), 1);

    // one 30-cycle interval while locked
    idle(29); pulse();
    check("early_pulse",  int'(o_err_early), 1);
    check("early_unlock", int'(o_locked),    0);
    check("early_errs",   int'(o_err_cnt),   1);
    check("early_period", int'(o_period),    30);
    verify4("relock");

    // drop one strobe while locked
    idle(DIV);
    check("miss_pulse", int'(o_err_miss), 1);
    check("miss_errs",  int'(o_err_cnt),  2);
`ifdef SYNC_FLYWHEEL_EN
    check("fly_locked", int'(o_locked), 1);
    check("fly_strobe", int'(o_strobe), 1);
    idle(DIV);
    check("fly_miss2",   int'(o_err_miss), 1);
    check("fly_unlock",  int'(o_locked),   0);
    check("fly_nostrb",  int'(o_strobe),   0);
    check("fly_errs",    int'(o_err_cnt),  3);
`else
    check("miss_unlock", int'(o_locked), 0);
    check("miss_nostrb", int'(o_strobe), 0);
`endif

    // async reset between strobes while locked
    pulse();
    verify4("prereset");
    idle(20);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_locked", int'(o_locked),  0);
    check("arst_strobe", int'(o_strobe),  0);
    check("arst_phase",  int'(o_phase),   0);
    check("arst_period", int'(o_period),  0);
    check("arst_errs",   int'(o_err_cnt), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pulse();
    verify4("postreset");

    // 300 early errors saturate the counter; clear beats a coincident error
    for (int i = 0; i < 300; i++) begin
      idle(9); pulse();
    end
    check("sat_errs",  int'(o_err_cnt), 255);
    check("sat_model", m_errs,          255);
    idle(9);
    step(1'b1, 1'b1);
    check("clr_early", int'(o_err_early), 1);
    check("clr_errs",  int'(o_err_cnt),   0);

    // random traffic: mostly correct periods, some odd gaps and skipped strobes
    rnd_clear = 1'b1;
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      gap = DIV;
      else if (r < 85) gap = $urandom_range(1, DIV + 10);
      else             gap = 0;
      if (gap == 0) idle(DIV);
      else begin pulse(); idle(gap - 1); end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
